// File: rtl/alu_seq_unit_pkg.sv
// Shared encodings for the sequential ALU: operation codes, alu_op classes
// and the controller state type.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the ID/EX register (master) and the ALU (slave).
interface alu_seq_unit_if #(
  parameter int WIDTH = 64
) ();
  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and the
  // payload must be stable only in the cycle of that edge.
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [3:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [3:0]       operation;
  logic             illegal;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, operation, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, operation, illegal
  );
endinterface

// File: rtl/alu_seq_unit_decode.sv
// Combinational ALU-control decoder: alu_op/funct to operation code plus
// an illegal flag for funct values with no defined operation.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] funct,
  output logic [3:0] operation,
  output logic       illegal
);

  always_comb begin
    operation = OP_ADD;
    illegal   = 1'b0;
    case (alu_op)
      ALU_OP_MEM:    operation = OP_ADD;
      ALU_OP_BRANCH: operation = OP_SUB;
      ALU_OP_RTYPE: begin
        case (funct)
          4'b0000: operation = OP_ADD;
          4'b1000: operation = OP_SUB;
          4'b0111: operation = OP_AND;
          4'b0110: operation = OP_OR;
          4'b0100: operation = OP_XOR;
          4'b0001: operation = OP_SLL;
          4'b0101: operation = OP_SRL;
          4'b1101: operation = OP_SRA;
          4'b0010: operation = OP_SLT;
          4'b0011: operation = OP_SLTU;
          default: illegal   = 1'b1;
        endcase
      end
      default: begin
        // I-type has no SUB; funct[3] only selects arithmetic right shift.
        case (funct[2:0])
          3'b000: operation = OP_ADD;
          3'b111: operation = OP_AND;
          3'b110: operation = OP_OR;
          3'b100: operation = OP_XOR;
          3'b001: operation = OP_SLL;
          3'b101: operation = funct[3] ? OP_SRA : OP_SRL;
          3'b010: operation = OP_SLT;
          3'b011: operation = OP_SLTU;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// EX-stage ALU with registered result: single-cycle arithmetic/logic, and
// shifts iterated one bit position per cycle with valid/ready on both sides.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  alu_seq_unit_if.slave  bus,
  output state_t         state_dbg
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       dec_op;
  logic             dec_illegal;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_one;
  logic [SHW-1:0]   shamt;
  logic             in_ready;
  logic             accept;

  alu_decode u_decode (
    .alu_op   (bus.alu_op),
    .funct    (bus.funct),
    .operation(dec_op),
    .illegal  (dec_illegal)
  );

  assign shamt    = bus.b[SHW-1:0];
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    alu_res = bus.a + bus.b;
    case (dec_op)
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: ;
    endcase
  end

  // The result register doubles as the shift working register.
  always_comb begin
    shift_one = result_q;
    case (op_q)
      OP_SLL:  shift_one = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  shift_one = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept) begin
      op_d      = dec_op;
      illegal_d = dec_illegal;
      if (is_shift(dec_op)) begin
        result_d = bus.a;
        cnt_d    = shamt;
        state_d  = (shamt == '0) ? ST_DONE : ST_SHIFT;
      end else begin
        result_d = alu_res;
        cnt_d    = '0;
        state_d  = ST_DONE;
      end
      zero_d = (result_d == '0);
    end else begin
      case (state_q)
        ST_SHIFT: begin
          result_d = shift_one;
          cnt_d    = cnt_q - CNT_ONE;
          zero_d   = (shift_one == '0);
          if (cnt_q == CNT_ONE) state_d = ST_DONE;
        end
        ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
        default: ;
      endcase
    end
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      cnt_q       <= '0;
      op_q        <= 4'b0000;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.operation = op_q;
  assign bus.illegal   = illegal_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed literal cases plus randomized traffic,
// all compared every cycle against a transaction-level model.
module tb_alu_seq_unit;
  import alu_pkg::*;

  localparam int W = 64;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   op;
    logic         ill;
    int           rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] last_op;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: canonicalise I-type to its R-type funct, then evaluate.
  function automatic exp_t model(input logic [1:0] aop, input logic [3:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input int now);
    exp_t       e;
    logic [3:0] rf;
    int         k;
    k     = int'(b) & (W - 1);
    e.op  = 4'b0010;
    e.res = a + b;
    e.ill = 1'b0;
    e.rdy = now;
    if (aop == 2'b00)      rf = 4'b0000;
    else if (aop == 2'b01) rf = 4'b1000;
    else if (aop == 2'b11) rf = (f[2:0] == 3'b101) ? f : {1'b0, f[2:0]};
    else                   rf = f;
    case (rf)
      4'b0000: ;
      4'b1000: begin e.op = 4'b0110; e.res = a - b; end
      4'b0111: begin e.op = 4'b0000; e.res = a & b; end
      4'b0110: begin e.op = 4'b0001; e.res = a | b; end
      4'b0100: begin e.op = 4'b0011; e.res = a ^ b; end
      4'b0001: begin e.op = 4'b0100; e.res = a << k; e.rdy = now + k; end
      4'b0101: begin e.op = 4'b0101; e.res = a >> k; e.rdy = now + k; end
      4'b1101: begin e.op = 4'b0111; e.res = $signed(a) >>> k; e.rdy = now + k; end
      4'b0010: begin e.op = 4'b1000; e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; end
      4'b0011: begin e.op = 4'b1001; e.res = (a < b) ? 64'd1 : 64'd0; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: check in_ready, record handshakes, advance, compare outputs.
  task automatic step();
    logic exp_ir, exp_v, acc, pop;
    exp_t e;
    #1;
    exp_v  = (exp_q.size() > 0) && (cyc >= exp_q[0].rdy);
    exp_ir = (exp_q.size() == 0) || (exp_v && bus.out_ready);
    chk("in_ready", bus.in_ready, exp_ir);
    acc = bus.in_valid && exp_ir;
    pop = exp_v && bus.out_ready;
    if (acc) e = model(bus.alu_op, bus.funct, bus.a, bus.b, cyc + 1);
    @(posedge clk);
    cyc++;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(e);
      last_op = e.op;
    end
    @(negedge clk);
    exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].rdy);
    chk("out_valid", bus.out_valid, exp_v);
    chk("operation", bus.operation, last_op);
    if (exp_v) begin
      chk("result", bus.result, exp_q[0].res);
      chk("zero", bus.zero, exp_q[0].res == '0);
      chk("illegal", bus.illegal, exp_q[0].ill);
    end
  endtask

  task automatic directed(input string name, input logic [1:0] aop, input logic [3:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_res, input logic [3:0] e_op,
                          input logic e_ill, input int e_lat);
    int lat;
    bus.in_valid  = 1'b1;
    bus.alu_op    = aop;
    bus.funct     = f;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    lat = 1;
    while (!bus.out_valid && lat < 2 * W) begin
      step();
      lat++;
    end
    chk({name, " latency"}, lat, e_lat);
    chk({name, " result"}, bus.result, e_res);
    chk({name, " zero"}, bus.zero, e_res == '0);
    chk({name, " operation"}, bus.operation, e_op);
    chk({name, " illegal"}, bus.illegal, e_ill);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset         = 1'b1;
    last_op       = 4'b0000;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = 4'b0000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset result", bus.result, '0);
    chk("reset zero", bus.zero, 1'b0);
    chk("reset operation", bus.operation, 4'b0000);
    chk("reset illegal", bus.illegal, 1'b0);
    chk("reset state", state_dbg, ST_IDLE);
    reset = 1'b0;
    #1;
    chk("reset in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    directed("add_wrap",  2'b10, 4'b0000, '1, 64'd1, '0, 4'b0010, 1'b0, 1);
    directed("sub_eq",    2'b10, 4'b1000, 64'd5, 64'd5, '0, 4'b0110, 1'b0, 1);
    directed("and",       2'b10, 4'b0111, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F,
             64'h0F00_0F00_0F00_0F00, 4'b0000, 1'b0, 1);
    directed("or",        2'b10, 4'b0110, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F,
             64'hFF0F_FF0F_FF0F_FF0F, 4'b0001, 1'b0, 1);
    directed("slt",       2'b10, 4'b0010, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 4'b1000, 1'b0, 1);
    directed("sltu",      2'b10, 4'b0011, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 4'b1001, 1'b0, 1);
    directed("sra63",     2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd63, '1, 4'b0111, 1'b0, 64);
    directed("srl63",     2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0101, 1'b0, 64);
    directed("sll0",      2'b10, 4'b0001, 64'h1234, 64'd0, 64'h1234, 4'b0100, 1'b0, 1);
    directed("sll_hi_b",  2'b10, 4'b0001, 64'd1, 64'h103, 64'd8, 4'b0100, 1'b0, 4);
    directed("i_sra",     2'b11, 4'b1101, 64'hF000_0000_0000_0000, 64'd4,
             64'hFF00_0000_0000_0000, 4'b0111, 1'b0, 5);
    directed("i_srl",     2'b11, 4'b0101, 64'hF000_0000_0000_0000, 64'd4,
             64'h0F00_0000_0000_0000, 4'b0101, 1'b0, 5);
    directed("i_add_f3",  2'b11, 4'b1000, 64'd2, 64'd3, 64'd5, 4'b0010, 1'b0, 1);
    directed("branch",    2'b01, 4'b0000, 64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110, 1'b0, 1);
    directed("illegal",   2'b10, 4'b1111, 64'd3, 64'd4, 64'd7, 4'b0010, 1'b1, 1);

    // Backpressure, then a queued request accepted in the handshake cycle.
    bus.in_valid = 1'b1; bus.alu_op = 2'b00; bus.a = 64'd10; bus.b = 64'd20;
    step();
    bus.a = 64'd100; bus.b = 64'd23;
    repeat (5) begin
      step();
      chk("hold result", bus.result, 64'd30);
      chk("hold in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("b2b out_valid", bus.out_valid, 1'b1);
    chk("b2b result", bus.result, 64'd123);
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;

    // Reset while a long shift is in flight.
    bus.in_valid = 1'b1; bus.alu_op = 2'b10; bus.funct = 4'b0001; bus.a = 64'd1; bus.b = 64'd40;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("abort out_valid", bus.out_valid, 1'b0);
    chk("abort result", bus.result, '0);
    chk("abort zero", bus.zero, 1'b0);
    chk("abort operation", bus.operation, 4'b0000);
    chk("abort illegal", bus.illegal, 1'b0);
    exp_q.delete();
    last_op = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    repeat (3) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'($urandom_range(0, 3));
        bus.funct    = 4'($urandom_range(0, 15));
        bus.a        = rand_operand();
        bus.b        = rand_operand();
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2 * W) step();
    chk("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the combinational ALU-control decoder: it decodes `alu_op`/`funct` into a 4-bit operation code, executes the operation on WIDTH-bit operands and returns a registered result with a zero flag. Shifts are iterative, one bit position per cycle, so the block is multi-cycle with valid/ready on both sides. It sits in the EX stage between the ID/EX pipeline register and the EX/MEM register; `in_ready` low is the stall source for the pipeline.

## Interface
- WIDTH, 64: operand/result width; power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- alu_op  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
- funct  in  4  {funct7[5], funct3}.
- a, b  in  WIDTH  operands; shift amount = b[SHW-1:0].
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  registered, 1 when result == 0.
- operation  out  4  decoded code of the in-flight/last accepted request.
- illegal  out  1  registered; unsupported funct under alu_op 10/11.

## Operation
- Decode: alu_op 00 → ADD 0010; 01 → SUB 0110; 10: funct 0000 ADD, 1000 SUB, 0111 AND 0000, 0110 OR 0001, 0100 XOR 0011, 0001 SLL 0100, 0101 SRL 0101, 1101 SRA 0111, 0010 SLT 1000, 0011 SLTU 1001; 11: same as 10 with funct[3] ignored except for funct[2:0]=101 (1 → SRA, 0 → SRL); SUB not encodable under 11.
- Unlisted funct: operation = ADD, illegal = 1, result computed as ADD.
- Arithmetic: ADD/SUB modulo 2^WIDTH, carry discarded; SLT signed, SLTU unsigned, result zero-extended 0/1; SRA replicates a[WIDTH-1].
- States: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. Accept (in_valid): non-shift → compute, load result, go DONE. Shift with amount 0 → load a, go DONE. Shift amount k>0 → load a into working register, counter=k, go SHIFT.
  - SHIFT: one bit per cycle in the decoded direction; counter decrements; at counter reaching 0 the shifted value is in result, go DONE. in_ready=0.
  - DONE: out_valid=1, result/zero/illegal stable. in_ready = out_ready. out_ready & in_valid → accept new request in the same cycle (back-to-back, processed as from IDLE). out_ready & !in_valid → IDLE.
- out_valid deasserts only by consumer handshake or reset; no result is ever dropped or overwritten before handshake.
- zero derived from the final result, including SLT/SLTU and shift results.

## Timing
- Reset values: state IDLE, in_ready 1 after reset release, out_valid 0, result 0, zero 0, operation 0000, illegal 0, counter 0.
- Non-shift or shift-by-0 accepted at edge N → out_valid high after edge N+1... i.e. visible in cycle N+1 (latency 1).
- Shift by k>0 accepted at edge N → out_valid in cycle N+1+k; max latency WIDTH.
- Throughput with out_ready held high: one single-cycle op per cycle.
- in_valid/operands sampled only on the accept edge; later changes ignored.
- Reset asserted mid-SHIFT or in DONE: request aborted, no out_valid, outputs return to reset values asynchronously.
- out_ready while out_valid=0: ignored.

## Structure
- Package `alu_pkg`: 4-bit operation localparams (OP_AND … OP_SLTU), alu_op encodings, state enum type.
- Sub-module `alu_decode`: purely combinational alu_op/funct → {operation, illegal}; instantiated once. Datapath, shifter iteration and FSM in the top.

## Test plan
- Reset mid-flight: SLL a=1, b=40 accepted, assert reset after 10 cycles → out_valid 0 immediately, result 0, in_ready 1 after release.
- R-type ADD/SUB/AND/OR, WIDTH=64: a=0xFFFF_FFFF_FFFF_FFFF, b=1 → ADD result 0, zero=1, latency 1; SUB a=5,b=5 → 0, zero=1.
- SLT vs SLTU: a=0x8000_0000_0000_0000, b=1 → SLT 1, SLTU 0, operation 1000/1001.
- Shifts: SRA a=0x8000_0000_0000_0000, b=63 → all ones after 64 cycles; SRL same → 1; SLL b=0 → a, latency 1; I-type funct 1101 with funct[3] forcing SRA.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles → result stable, in_ready 0; then out_ready=1 with queued ADD → accepted same cycle, next result one cycle later.
- Illegal: alu_op=10, funct=1111 → operation 0010, illegal 1, result a+b.
